// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/D memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (IF and D ports) and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the surrounding core + memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// own the memory last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  owner_t     last_owner,
    output logic       gnt_valid,
    output owner_t     gnt_owner
);
    always_comb begin
        gnt_valid = |elig;
        gnt_owner = OWNER_IF;
        unique case (elig)
            2'b01:   gnt_owner = OWNER_IF;
            2'b10:   gnt_owner = OWNER_D;
            2'b11:   gnt_owner = (last_owner == OWNER_IF) ? OWNER_D : OWNER_IF;
            default: gnt_owner = OWNER_IF;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch (IF) and data (D) ports.
// Optional grant timeout enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no access in flight; picks the next port round-robin
// GNT_IF | fetch issued, waiting for mem_ack
// GNT_D  | load/store issued, waiting for mem_ack
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [1:0]        elig;
    logic              gnt_valid;
    owner_t            gnt_owner;
    logic              tmo;
    logic              abort;

    // A port in its done cycle is not eligible, so a held req is not re-served.
    assign elig = {bus.d_req & ~d_done_q, bus.if_req & ~if_done_q};

    rr_pick2 u_pick (
        .elig       (elig),
        .last_owner (owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q;
    logic          err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= (state_q == IDLE) ? '0 : tmr_q + TW'(1);
            err_q <= abort;
        end
    end

    assign tmo     = (state_q != IDLE) && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tmo            = 1'b0;
    assign bus.err        = 1'b0;
`endif

    // An ack arriving together with the timeout completes normally.
    assign abort = tmo & ~bus.mem_ack;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    mem_req_d = 1'b1;
                    if (gnt_owner == OWNER_IF) begin
                        mem_addr_d = bus.if_addr;
                        mem_we_d   = 1'b0;
                        state_d    = GNT_IF;
                    end else begin
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                        state_d     = GNT_D;
                    end
                end
            end
            GNT_IF: begin
                if (bus.mem_ack || tmo) begin
                    if_rdata_d = abort ? DATA_W'(TIMEOUT_DATA) : bus.mem_rdata;
                    if_done_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    owner_d    = OWNER_IF;
                    state_d    = IDLE;
                end
            end
            GNT_D: begin
                if (bus.mem_ack || tmo) begin
                    if (abort)
                        d_rdata_d = DATA_W'(TIMEOUT_DATA);
                    else if (!mem_we_q)
                        d_rdata_d = bus.mem_rdata;
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    owner_d   = OWNER_D;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized
// IF/D traffic against a behavioural memory and round-robin reference model.
module tb_mem_port_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    bit          grant_log[$];
    logic [31:0] mem_store[logic [31:0]];
    logic [31:0] d_shadow[logic [31:0]];
    logic [31:0] d_last   = 32'h0;
    bit          lo_m     = 1'b1;
    bit          exp_tmo  = 1'b0;
    bit          mem_ack_en = 1'b1;
    bit          stray_en = 1'b0;
    int          mem_lat  = 3;
    int          lat_cnt  = -1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h40) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input bit is_if, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (is_if ? bus.if_done : bus.d_done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk(is_if ? "if_wait" : "d_wait", 32'd0, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        exp_if_q.push_back(rom(a));
        wait_done(1'b1, lat);
        bus.if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd, output int lat);
        logic [31:0] v;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        if (we) begin
            d_shadow[a] = wd;
            exp_d_q.push_back(d_last);
        end else begin
            v = d_shadow.exists(a) ? d_shadow[a] : rom(a);
            d_last = v;
            exp_d_q.push_back(v);
        end
        wait_done(1'b0, lat);
        bus.d_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_if_q.delete();
        exp_d_q.delete();
        lo_m   = 1'b1;
        d_last = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Memory: acks after a (fixed or random) number of mem_req cycles.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (!reset) begin
                lat_cnt = -1;
            end else if (bus.mem_req && mem_ack_en) begin
                if (lat_cnt < 0) lat_cnt = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.mem_ack = 1'b1;
                    lat_cnt     = -1;
                    if (bus.mem_we) begin
                        mem_store[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = $urandom;
                    end else begin
                        bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                                       : rom(bus.mem_addr);
                    end
                end
            end else if (!bus.mem_req && stray_en && $urandom_range(0, 7) == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks grants against the round-robin rule and done pulses
    // against the scoreboard queues.
    initial begin
        bit          own, ok;
        bit          p_elig_if = 0, p_elig_d = 0, p_mem_req = 0, p_if_done = 0, p_d_done = 0, p_d_we = 0;
        logic [31:0] p_if_addr = 0, p_d_addr = 0, p_d_wdata = 0, p_mem_addr = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.mem_req && !p_mem_req) begin
                    ok = 1'b1;
                    own = 1'b0;
                    if (p_elig_if && p_elig_d) own = ~lo_m;
                    else if (p_elig_if)        own = 1'b0;
                    else if (p_elig_d)         own = 1'b1;
                    else begin
                        ok = 1'b0;
                        chk("spurious_grant", 32'd1, 32'd0);
                    end
                    if (ok) begin
                        grant_log.push_back(own);
                        if (!own) begin
                            chk("grant_if_addr", bus.mem_addr, p_if_addr);
                            chk("grant_if_we", {31'd0, bus.mem_we}, 32'd0);
                        end else begin
                            chk("grant_d_addr", bus.mem_addr, p_d_addr);
                            chk("grant_d_we", {31'd0, bus.mem_we}, {31'd0, p_d_we});
                            if (p_d_we) chk("grant_d_wdata", bus.mem_wdata, p_d_wdata);
                        end
                    end
                end else if (bus.mem_req && p_mem_req && bus.mem_addr !== p_mem_addr) begin
                    chk("mem_addr_stable", bus.mem_addr, p_mem_addr);
                end
                if (bus.if_done) begin
                    if (exp_if_q.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
                    else chk("if_rdata", bus.if_rdata, exp_if_q.pop_front());
                    chk("if_done_pulse", {31'd0, p_if_done}, 32'd0);
                    chk("if_done_mem_req", {31'd0, bus.mem_req}, 32'd0);
                    chk("if_err", {31'd0, bus.err}, 32'd0);
                    lo_m = 1'b0;
                end
                if (bus.d_done) begin
                    if (exp_d_q.size() == 0) chk("d_done_unexpected", 32'd1, 32'd0);
                    else chk("d_rdata", bus.d_rdata, exp_d_q.pop_front());
                    chk("d_done_pulse", {31'd0, p_d_done}, 32'd0);
                    chk("d_done_mem_req", {31'd0, bus.mem_req}, 32'd0);
                    chk("d_err", {31'd0, bus.err}, {31'd0, exp_tmo});
                    lo_m = 1'b1;
                end
                if (bus.err && !bus.if_done && !bus.d_done) chk("err_stray", 32'd1, 32'd0);
            end
            p_elig_if  = bus.if_req && !bus.if_done;
            p_elig_d   = bus.d_req && !bus.d_done;
            p_if_addr  = bus.if_addr;
            p_d_addr   = bus.d_addr;
            p_d_we     = bus.d_we;
            p_d_wdata  = bus.d_wdata;
            p_mem_req  = bus.mem_req;
            p_mem_addr = bus.mem_addr;
            p_if_done  = bus.if_done;
            p_d_done   = bus.d_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;

        #12;
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_if_done", {31'd0, bus.if_done}, 32'd0);
        chk("rst_d_done", {31'd0, bus.d_done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(1);

        // Lone fetch, ack three cycles into mem_req.
        mem_lat = 3;
        do_fetch(32'h40, lat);
        chk("lone_fetch_latency", lat, 32'd4);
        idle_cycles(1);

        // Store then load of the same word.
        do_data(1'b1, 32'h100, 32'h1234_5678, lat);
        chk("store_keeps_d_rdata", bus.d_rdata, 32'h0);
        idle_cycles(1);
        do_data(1'b0, 32'h100, 32'h0, lat);
        idle_cycles(2);

        // Both ports request straight after reset; IF holds its req through if_done.
        do_reset();
        mem_lat = 1;
        grant_log.delete();
        fork
            begin
                do_fetch(32'h44, lat);
                chk("min_latency", lat, 32'd2);
                do_fetch(32'h48, lat);
            end
            begin
                do_data(1'b0, 32'h104, 32'h0, lat);
            end
        join
        chk("grant_count", grant_log.size(), 32'd3);
        if (grant_log.size() >= 3) begin
            chk("grant_order_0", {31'd0, grant_log[0]}, 32'd0);
            chk("grant_order_1", {31'd0, grant_log[1]}, 32'd1);
            chk("grant_order_2", {31'd0, grant_log[2]}, 32'd0);
        end
        idle_cycles(2);

        // Reset while a load is stalled in the grant state.
        mem_ack_en  = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h10C;
        idle_cycles(3);
        chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_d_done", {31'd0, bus.d_done}, 32'd0);
        end
        bus.d_req = 1'b0;
        exp_if_q.delete();
        exp_d_q.delete();
        lo_m   = 1'b1;
        d_last = 32'h0;
        @(posedge clk); #1;
        reset      = 1'b1;
        mem_ack_en = 1'b1;
        mem_lat    = 2;
        do_fetch(32'h50, lat);
        chk("post_rst_fetch_latency", lat, 32'd3);
        chk("post_rst_d_rdata", bus.d_rdata, 32'h0);
        idle_cycles(2);

        // Randomized concurrent traffic with random latency and stray acks.
        mem_lat  = 0;
        stray_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    idle_cycles(int'($urandom_range(0, 2)));
                    do_fetch(32'h40 + 32'(4 * $urandom_range(0, 15)), lat);
                    chk("rand_if_latency_min", {31'd0, lat >= 2}, 32'd1);
                end
            end
            begin
                for (int j = 0; j < 120; j++) begin
                    idle_cycles(int'($urandom_range(0, 2)));
                    do_data(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, lat);
                    chk("rand_d_latency_min", {31'd0, lat >= 2}, 32'd1);
                end
            end
        join
        stray_en = 1'b0;
        idle_cycles(3);
        chk("if_queue_drained", exp_if_q.size(), 32'd0);
        chk("d_queue_drained", exp_d_q.size(), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never acks: the grant is aborted after TIMEOUT_CYCLES (8) cycles.
        mem_ack_en  = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h108;
        d_last      = 32'hDEAD_BEEF;
        exp_d_q.push_back(32'hDEAD_BEEF);
        exp_tmo     = 1'b1;
        wait_done(1'b0, lat);
        bus.d_req   = 1'b0;
        chk("timeout_latency", lat, 32'd9);
        chk("timeout_err", {31'd0, bus.err}, 32'd1);
        idle_cycles(1);
        exp_tmo    = 1'b0;
        mem_ack_en = 1'b1;
        mem_lat    = 1;
        do_fetch(32'h60, lat);
        chk("after_timeout_fetch_latency", lat, 32'd2);
        idle_cycles(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
